seq_validator: RTL
==================

SEQ_VALIDATOR -- requirements
Module: seq_validator

Interface
REQ-001 SHALL have parameter NUM_SESSION, default 3, number of FIX sessions tracked.
REQ-002 SHALL have parameter SES_W, default 2, session index width.
REQ-003 SHALL have parameter SEQW, default 32, MsgSeqNum width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: port clk (input, 1 bit, rising-edge clock), then port rst (input, 1 bit, synchronous active-high reset).
REQ-005 msg_valid_i  input  1  parsed inbound header present.
REQ-006 msg_ready_o  output  1  block can accept a header this cycle.
REQ-007 session_i  input  SES_W  session of inbound message.
REQ-008 msg_seq_i  input  SEQW  received MsgSeqNum (tag 34).
REQ-009 msg_type_i  input  4  decoded MsgType code.
REQ-010 checksum_ok_i  input  1  tag 10 matched.
REQ-011 body_len_ok_i  input  1  tag 9 matched.
REQ-012 poss_dup_i  input  1  PossDupFlag (tag 43) = Y.
REQ-013 seq_set_i  input  1  session-manager command to overwrite the expected sequence number.
REQ-014 seq_set_session_i  input  SES_W  target session of seq_set_i.
REQ-015 seq_set_value_i  input  SEQW  new expected value.
REQ-016 new_message_o  output  1  one-cycle verdict strobe.
REQ-017 validity_o  output  3  verdict code.
REQ-018 message_type_o  output  4  msg_type_i of the judged message.
REQ-019 session_o  output  SES_W  session of the judged message.
REQ-020 expected_seq_o  output  SEQW  expected value at judgment, used for ResendRequest BeginSeqNo.
REQ-021 received_seq_o  output  SEQW  msg_seq_i of the judged message.

Function
REQ-022 Validity codes SHALL be: valid 3'b000, msgSeqH 3'b001, garbled 3'b010, msgSeqL 3'b011, dupIgnore 3'b100.
REQ-023 The FSM SHALL have states IDLE, LOOKUP and DECIDE; msg_ready_o SHALL be 1 only in IDLE with rst low.
REQ-024 IDLE -> LOOKUP SHALL occur on msg_valid_i & msg_ready_o; the block SHALL capture all header inputs on that edge.
REQ-025 LOOKUP SHALL read the expected counter of the captured session; LOOKUP -> DECIDE SHALL be unconditional.
REQ-026 DECIDE -> IDLE SHALL be unconditional; the verdict outputs SHALL register on the DECIDE edge, so new_message_o is high exactly 1 cycle, 3 cycles after acceptance, sustaining 1 message per 3 cycles.
REQ-027 The verdict SHALL be garbled if checksum_ok_i=0, body_len_ok_i=0, or session index >= NUM_SESSION; the counter SHALL be unchanged.
REQ-028 The verdict SHALL be valid if seq == expected; the counter SHALL increment, and 2^SEQW-1 SHALL wrap to 1, never 0.
REQ-029 The verdict SHALL be msgSeqH if seq > expected; the counter SHALL be unchanged.
REQ-030 If seq < expected and poss_dup_i=1, the verdict SHALL be dupIgnore, else msgSeqL; the counter SHALL be unchanged in both cases.
REQ-031 Comparisons SHALL be unsigned over SEQW bits.
REQ-032 seq_set_i SHALL write the counter on the next edge in any FSM state, and SHALL be ignored if seq_set_session_i >= NUM_SESSION.
REQ-033 When seq_set_i and a DECIDE increment target the same session in the same cycle, seq_set_value_i SHALL win; the verdict SHALL still use the pre-set value.
REQ-034 A seq_set_i in LOOKUP to the in-flight session SHALL be forwarded, so DECIDE compares against seq_set_value_i.
REQ-035 Verdict outputs other than new_message_o SHALL hold until the next verdict.

Reset
REQ-036 On rst, all counters SHALL be set to 1 and the FSM SHALL go to IDLE.
REQ-037 On rst, new_message_o, validity_o, message_type_o, session_o, expected_seq_o and received_seq_o SHALL be 0, and msg_ready_o SHALL be 0.
REQ-038 An rst during LOOKUP or DECIDE SHALL drop the in-flight message with no verdict and no counter change.

Structure
REQ-039 Validity codes, MsgType codes and the FSM state encoding SHALL live in the shared package fix_pkg.
REQ-040 Counter storage SHALL be sub-module seq_counter_bank: NUM_SESSION x SEQW registers, one read port, one write port with set priority.

Verification
REQ-041 Reset, then session 0, seq 1, checks ok -> valid, expected_seq_o=1, counter 2.
REQ-042 Session 1 expects 5, seq 9 -> msgSeqH, expected_seq_o=5, received_seq_o=9, counter stays 5.
REQ-043 Session 2 expects 7: seq 3 with poss_dup_i=1 -> dupIgnore; seq 3 with poss_dup_i=0 -> msgSeqL; counter stays 7 in both.
REQ-044 checksum_ok_i=0 or session_i=3 -> garbled, no counter changes.
REQ-045 Seq_set session 0 to 20 in LOOKUP of a session 0 seq 20 message -> valid, counter 21; set to 50 in the same cycle as a DECIDE increment -> counter 50.
REQ-046 Counter 2^32-1 with a matching seq -> valid, counter 1; rst asserted in LOOKUP -> no new_message_o, counters 1.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared FIX session-layer definitions: verdict codes, MsgType codes and the
// validator FSM encoding.
package fix_pkg;

    typedef enum logic [2:0] {
        VAL_VALID      = 3'b000,
        VAL_SEQ_H      = 3'b001,
        VAL_GARBLED    = 3'b010,
        VAL_SEQ_L      = 3'b011,
        VAL_DUP_IGNORE = 3'b100
    } validity_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DECIDE = 2'd2
    } state_e;

    // Decoded MsgType codes produced by the upstream header parser.
    localparam logic [3:0] MT_HEARTBEAT      = 4'd0;
    localparam logic [3:0] MT_TEST_REQUEST   = 4'd1;
    localparam logic [3:0] MT_RESEND_REQUEST = 4'd2;
    localparam logic [3:0] MT_REJECT         = 4'd3;
    localparam logic [3:0] MT_SEQUENCE_RESET = 4'd4;
    localparam logic [3:0] MT_LOGOUT         = 4'd5;
    localparam logic [3:0] MT_LOGON          = 4'd6;
    localparam logic [3:0] MT_EXEC_REPORT    = 4'd7;
    localparam logic [3:0] MT_NEW_ORDER      = 4'd8;
    localparam logic [3:0] MT_OTHER          = 4'd15;

endpackage

// File: rtl/seq_counter_bank.sv
// Per-session expected-MsgSeqNum registers: one read port, one increment port
// and one set port; set wins when both target the same session.
module seq_counter_bank #(
    parameter int NUM_SESSION = 3,
    parameter int SES_W       = 2,
    parameter int SEQW        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SES_W-1:0] rd_session_i,
    output logic [SEQW-1:0]  rd_data_o,
    input  logic             inc_en_i,
    input  logic [SES_W-1:0] inc_session_i,
    input  logic [SEQW-1:0]  inc_value_i,
    input  logic             set_en_i,
    input  logic [SES_W-1:0] set_session_i,
    input  logic [SEQW-1:0]  set_value_i
);

    logic [SEQW-1:0] cnt_q [NUM_SESSION];

    // Out-of-range sessions read as zero; their messages are judged garbled.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_SESSION; i++) begin
            if (int'(rd_session_i) == i) rd_data_o = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SESSION; i++) cnt_q[i] <= SEQW'(1);
        end else begin
            for (int i = 0; i < NUM_SESSION; i++) begin
                if (set_en_i && int'(set_session_i) == i) begin
                    cnt_q[i] <= set_value_i;
                end else if (inc_en_i && int'(inc_session_i) == i) begin
                    cnt_q[i] <= inc_value_i;
                end
            end
        end
    end

endmodule

// File: rtl/seq_validator.sv
// FIX inbound MsgSeqNum validator: accepts one parsed header per three cycles
// and emits a verdict against the per-session expected sequence number.
module seq_validator
    import fix_pkg::*;
#(
    parameter int NUM_SESSION = 3,
    parameter int SES_W       = 2,
    parameter int SEQW        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_valid_i,
    output logic             msg_ready_o,
    input  logic [SES_W-1:0] session_i,
    input  logic [SEQW-1:0]  msg_seq_i,
    input  logic [3:0]       msg_type_i,
    input  logic             checksum_ok_i,
    input  logic             body_len_ok_i,
    input  logic             poss_dup_i,
    input  logic             seq_set_i,
    input  logic [SES_W-1:0] seq_set_session_i,
    input  logic [SEQW-1:0]  seq_set_value_i,
    output logic             new_message_o,
    output logic [2:0]       validity_o,
    output logic [3:0]       message_type_o,
    output logic [SES_W-1:0] session_o,
    output logic [SEQW-1:0]  expected_seq_o,
    output logic [SEQW-1:0]  received_seq_o
);

    state_e           state_q, state_d;
    logic [SES_W-1:0] ses_q;
    logic [SEQW-1:0]  seq_q, exp_q, exp_d, rd_data, inc_value;
    logic [3:0]       type_q;
    logic             ck_q, bl_q, dup_q, accept, inc_en;
    validity_e        verdict;

    logic             new_msg_q;
    logic [2:0]       validity_q;
    logic [3:0]       mtype_q;
    logic [SES_W-1:0] ses_out_q;
    logic [SEQW-1:0]  exp_out_q, recv_out_q;

    // Handshake: a header transfers on a rising edge where msg_valid_i and
    // msg_ready_o are both high; ready is high only in IDLE outside reset.
    assign msg_ready_o = (state_q == ST_IDLE) && !rst;
    assign accept      = msg_valid_i && msg_ready_o;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ses_q  <= '0;
            seq_q  <= '0;
            type_q <= '0;
            ck_q   <= 1'b0;
            bl_q   <= 1'b0;
            dup_q  <= 1'b0;
        end else if (accept) begin
            ses_q  <= session_i;
            seq_q  <= msg_seq_i;
            type_q <= msg_type_i;
            ck_q   <= checksum_ok_i;
            bl_q   <= body_len_ok_i;
            dup_q  <= poss_dup_i;
        end
    end

    seq_counter_bank #(
        .NUM_SESSION(NUM_SESSION),
        .SES_W      (SES_W),
        .SEQW       (SEQW)
    ) u_bank (
        .clk          (clk),
        .rst          (rst),
        .rd_session_i (ses_q),
        .rd_data_o    (rd_data),
        .inc_en_i     (inc_en),
        .inc_session_i(ses_q),
        .inc_value_i  (inc_value),
        .set_en_i     (seq_set_i),
        .set_session_i(seq_set_session_i),
        .set_value_i  (seq_set_value_i)
    );

    // A set landing on the same edge as the lookup must be seen by DECIDE.
    assign exp_d = (seq_set_i && seq_set_session_i == ses_q) ? seq_set_value_i : rd_data;

    always_ff @(posedge clk) begin
        if (rst)                        exp_q <= '0;
        else if (state_q == ST_LOOKUP)  exp_q <= exp_d;
    end

    // MsgSeqNum 0 is never legal, so the counter wraps from all-ones to 1.
    assign inc_value = (exp_q == '1) ? SEQW'(1) : exp_q + SEQW'(1);

    always_comb begin
        verdict = VAL_VALID;
        inc_en  = 1'b0;
        if (!ck_q || !bl_q || int'(ses_q) >= NUM_SESSION) begin
            verdict = VAL_GARBLED;
        end else if (seq_q == exp_q) begin
            verdict = VAL_VALID;
            inc_en  = (state_q == ST_DECIDE);
        end else if (seq_q > exp_q) begin
            verdict = VAL_SEQ_H;
        end else if (dup_q) begin
            verdict = VAL_DUP_IGNORE;
        end else begin
            verdict = VAL_SEQ_L;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_msg_q  <= 1'b0;
            validity_q <= '0;
            mtype_q    <= '0;
            ses_out_q  <= '0;
            exp_out_q  <= '0;
            recv_out_q <= '0;
        end else begin
            new_msg_q <= (state_q == ST_DECIDE);
            if (state_q == ST_DECIDE) begin
                validity_q <= verdict;
                mtype_q    <= type_q;
                ses_out_q  <= ses_q;
                exp_out_q  <= exp_q;
                recv_out_q <= seq_q;
            end
        end
    end

    assign new_message_o  = new_msg_q;
    assign validity_o     = validity_q;
    assign message_type_o = mtype_q;
    assign session_o      = ses_out_q;
    assign expected_seq_o = exp_out_q;
    assign received_seq_o = recv_out_q;

endmodule
